// File: rtl/locked_vector_checker.sv
// Key-locked self-checking harness controller: walks NUM_VEC ROM vectors through an external core.
// Optional first-failure capture is enabled by defining LVC_FIRST_FAIL_EN.
module locked_vector_checker #(
    parameter int                DATA_W   = 64,
    parameter int                ADDR_W   = 5,
    parameter int                NUM_VEC  = 20,
    parameter int                CNT_W    = 8,
    parameter int                KEY_W    = 32,
    parameter logic [KEY_W-1:0]  LOCK_KEY = '0
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic              ap_start,
    output logic              ap_done,
    output logic              ap_idle,
    output logic              ap_ready,
    output logic [31:0]       ap_return,
    input  logic [KEY_W-1:0]  working_key,
    output logic [ADDR_W-1:0] vec_addr,
    output logic              vec_ce,
    input  logic [DATA_W-1:0] a_q,
    input  logic [DATA_W-1:0] b_q,
    input  logic [DATA_W-1:0] exp_q,
    output logic              dut_start,
    input  logic              dut_ready,
    input  logic              dut_done,
    output logic [DATA_W-1:0] dut_a,
    output logic [DATA_W-1:0] dut_b,
    input  logic [DATA_W-1:0] dut_return
`ifdef LVC_FIRST_FAIL_EN
    ,
    output logic              first_fail_vld,
    output logic [ADDR_W-1:0] first_fail_idx
`endif
);

    typedef enum logic [4:0] {
        S_IDLE   = 5'b00001,
        S_FETCH  = 5'b00010,
        S_LOAD   = 5'b00100,
        S_LAUNCH = 5'b01000,
        S_WAIT   = 5'b10000
    } state_t;

    // idx needs one extra bit so it can reach NUM_VEC == 2^ADDR_W
    localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W + 1)'(NUM_VEC);

    state_t            state, next_state;
    logic [ADDR_W:0]   idx;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] exp_r;
    logic              lock0, lock1, lock2;
    logic              mismatch;
    logic              unused_key;

    assign lock0 = (working_key[0] != LOCK_KEY[0]) && (idx[1:0] == 2'b01);
    assign lock1 = (working_key[1] != LOCK_KEY[1]) && (idx[3:2] == 2'b01);
    assign lock2 = (working_key[2] != LOCK_KEY[2]) && idx[4];
    assign unused_key = ^working_key;

    assign mismatch  = (dut_return != exp_r) ^ lock2;
    assign vec_addr  = idx[ADDR_W-1:0];
    assign ap_return = 32'(cnt);

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) state <= S_IDLE;
        else           state <= next_state;
    end

    always_comb begin
        next_state = state;
        ap_done    = 1'b0;
        ap_ready   = 1'b0;
        ap_idle    = 1'b0;
        vec_ce     = 1'b0;
        case (state)
            S_IDLE: begin
                ap_idle = !ap_start;
                if (ap_start) next_state = S_FETCH;
            end
            S_FETCH: begin
                vec_ce = 1'b1;
                if (idx == LAST_IDX) begin
                    ap_done    = 1'b1;
                    ap_ready   = 1'b1;
                    next_state = S_IDLE;
                end else if (lock0) begin
                    next_state = S_LAUNCH;
                end else begin
                    next_state = S_LOAD;
                end
            end
            S_LOAD:   next_state = S_LAUNCH;
            S_LAUNCH: if (dut_ready) next_state = S_WAIT;
            S_WAIT:   if (dut_done) next_state = S_FETCH;
            default:  next_state = S_IDLE;
        endcase
    end

    // dut_start is raised on entry to LAUNCH so it is high for every LAUNCH cycle
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            idx       <= '0;
            cnt       <= '0;
            dut_start <= 1'b0;
            dut_a     <= '0;
            dut_b     <= '0;
            exp_r     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (ap_start) begin
                        idx <= '0;
                        cnt <= '0;
                    end
                end
                S_FETCH: begin
                    if (idx != LAST_IDX && lock0) dut_start <= 1'b1;
                end
                S_LOAD: begin
                    dut_a     <= a_q;
                    dut_b     <= b_q;
                    exp_r     <= exp_q;
                    dut_start <= 1'b1;
                end
                S_LAUNCH: begin
                    if (dut_ready) dut_start <= 1'b0;
                end
                S_WAIT: begin
                    if (dut_done) begin
                        if (mismatch && cnt != '1) cnt <= cnt + 1'b1;
                        if (!lock1) idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef LVC_FIRST_FAIL_EN
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            first_fail_vld <= 1'b0;
            first_fail_idx <= '0;
        end else if (state == S_IDLE && ap_start) begin
            first_fail_vld <= 1'b0;
            first_fail_idx <= '0;
        end else if (state == S_WAIT && dut_done && mismatch && !first_fail_vld) begin
            first_fail_vld <= 1'b1;
            first_fail_idx <= idx[ADDR_W-1:0];
        end
    end
`endif

endmodule

// File: tb/tb_locked_vector_checker.sv
// Scoreboard bench for locked_vector_checker with ROM and core models; also covers LVC_FIRST_FAIL_EN when defined.
module tb_locked_vector_checker;

    localparam int          DATA_W   = 64;
    localparam int          ADDR_W   = 5;
    localparam int          NUM_VEC  = 20;
    localparam int          KEY_W    = 32;
    localparam int          D        = 3;
    localparam logic [31:0] LOCK_KEY = 32'h1234_5675;
    localparam int          NOM_LAT  = 1 + NUM_VEC * (3 + D) + 1;

    logic              ap_clk = 1'b0;
    logic              ap_rst_n, ap_start;
    logic [KEY_W-1:0]  working_key;
    logic [DATA_W-1:0] a_q, b_q, exp_q, dut_return;
    logic              dut_ready, dut_done;

    logic              ap_done, ap_idle, ap_ready, vec_ce, dut_start;
    logic [31:0]       ap_return;
    logic [ADDR_W-1:0] vec_addr;
    logic [DATA_W-1:0] dut_a, dut_b;

    logic              s_ap_done, s_ap_idle, s_ap_ready, s_vec_ce, s_dut_start;
    logic [31:0]       s_ap_return;
    logic [ADDR_W-1:0] s_vec_addr;
    logic [DATA_W-1:0] s_dut_a, s_dut_b;
`ifdef LVC_FIRST_FAIL_EN
    logic              ff_vld, s_ff_vld;
    logic [ADDR_W-1:0] ff_idx, s_ff_idx;
`endif

    always #5 ap_clk = ~ap_clk;

    locked_vector_checker #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_VEC(NUM_VEC), .CNT_W(8),
                            .KEY_W(KEY_W), .LOCK_KEY(LOCK_KEY)) u_main (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start), .ap_done(ap_done),
        .ap_idle(ap_idle), .ap_ready(ap_ready), .ap_return(ap_return), .working_key(working_key),
        .vec_addr(vec_addr), .vec_ce(vec_ce), .a_q(a_q), .b_q(b_q), .exp_q(exp_q),
        .dut_start(dut_start), .dut_ready(dut_ready), .dut_done(dut_done), .dut_a(dut_a),
        .dut_b(dut_b), .dut_return(dut_return)
`ifdef LVC_FIRST_FAIL_EN
        , .first_fail_vld(ff_vld), .first_fail_idx(ff_idx)
`endif
    );

    locked_vector_checker #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_VEC(NUM_VEC), .CNT_W(2),
                            .KEY_W(KEY_W), .LOCK_KEY(LOCK_KEY)) u_sat (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start), .ap_done(s_ap_done),
        .ap_idle(s_ap_idle), .ap_ready(s_ap_ready), .ap_return(s_ap_return), .working_key(working_key),
        .vec_addr(s_vec_addr), .vec_ce(s_vec_ce), .a_q(a_q), .b_q(b_q), .exp_q(exp_q),
        .dut_start(s_dut_start), .dut_ready(dut_ready), .dut_done(dut_done), .dut_a(s_dut_a),
        .dut_b(s_dut_b), .dut_return(dut_return)
`ifdef LVC_FIRST_FAIL_EN
        , .first_fail_vld(s_ff_vld), .first_fail_idx(s_ff_idx)
`endif
    );

    logic [DATA_W-1:0] a_rom [32];
    logic [DATA_W-1:0] b_rom [32];
    logic [DATA_W-1:0] e_rom [32];
    bit                err_vec [32];
    logic [ADDR_W-1:0] last_addr = '0;
    int                done_cnt = 0;

    // ROMs with 1-cycle latency; core model returns the reference of the last addressed vector
    always @(posedge ap_clk) begin
        if (vec_ce) begin
            a_q       <= a_rom[vec_addr];
            b_q       <= b_rom[vec_addr];
            exp_q     <= e_rom[vec_addr];
            last_addr <= vec_addr;
        end
        if (dut_start && dut_ready) begin
            done_cnt   <= D;
            dut_return <= e_rom[last_addr] ^ (err_vec[last_addr] ? 64'h1 : 64'h0);
        end else if (done_cnt > 0) begin
            done_cnt <= done_cnt - 1;
        end
    end
    assign dut_done = (done_cnt == 1);

    int checks = 0;
    int passes = 0;
    logic [31:0]       exp_ret_q[$];
    logic [31:0]       exp_sat_q[$];
    logic [DATA_W-1:0] exp_a_q[$];
    logic [DATA_W-1:0] exp_b_q[$];
    int stall = 0;
    int hs_cnt, first_pulse, first_addr;

    task automatic clear_errs();
        for (int i = 0; i < 32; i++) err_vec[i] = 1'b0;
    endtask

    task automatic expect_ret(input int n);
        exp_ret_q.push_back(32'(n));
        exp_sat_q.push_back(32'(n > 3 ? 3 : n));
    endtask

    task automatic push_ops();
        for (int i = 0; i < NUM_VEC; i++) begin
            exp_a_q.push_back(a_rom[i]);
            exp_b_q.push_back(b_rom[i]);
        end
    endtask

    task automatic do_reset();
        ap_rst_n = 1'b0;
        repeat (3) @(negedge ap_clk);
        ap_rst_n = 1'b1;
        @(negedge ap_clk);
    endtask

    task automatic run(input int limit, input bit chk_ops, output int lat, output bit done);
        int pulse_len;
        logic [DATA_W-1:0] ea, eb;
        logic [31:0] er, es;
        lat = 0; done = 1'b0; pulse_len = 0;
        hs_cnt = 0; first_pulse = 0; first_addr = -1;
        @(negedge ap_clk); ap_start = 1'b1; lat = 1;
        @(negedge ap_clk); ap_start = 1'b0;
        while (!done && lat < limit) begin
            lat++;
            dut_ready = (stall == 0);
            if (dut_start && stall > 0) stall--;
            if (vec_ce && first_addr < 0) first_addr = int'(vec_addr);
            if (dut_start) pulse_len++;
            else if (pulse_len > 0 && first_pulse == 0) first_pulse = pulse_len;
            if (dut_start && dut_ready) begin
                hs_cnt++;
                if (chk_ops) begin
                    checks++;
                    if (exp_a_q.size() == 0) $display("FAIL operand_underflow: got handshake %0d expected none", hs_cnt);
                    else begin
                        ea = exp_a_q.pop_front(); eb = exp_b_q.pop_front();
                        if (dut_a !== ea || dut_b !== eb)
                            $display("FAIL operands[%0d]: got %h/%h expected %h/%h", hs_cnt - 1, dut_a, dut_b, ea, eb);
                        else passes++;
                    end
                end
            end
            if (ap_done) begin
                done = 1'b1;
                checks++;
                if (ap_ready !== 1'b1) $display("FAIL ap_ready_with_done: got %b expected 1", ap_ready);
                else passes++;
                checks++;
                if (exp_ret_q.size() == 0) $display("FAIL ret_underflow: got %0d expected no completion", ap_return);
                else begin
                    er = exp_ret_q.pop_front(); es = exp_sat_q.pop_front();
                    if (ap_return !== er) $display("FAIL ap_return: got %0d expected %0d", ap_return, er);
                    else passes++;
                    checks++;
                    if (s_ap_return !== es) $display("FAIL ap_return_sat: got %0d expected %0d", s_ap_return, es);
                    else passes++;
                end
            end else begin
                @(negedge ap_clk);
            end
        end
        dut_ready = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge ap_clk);
        checks++;
        if ({ap_idle, ap_done, ap_ready, vec_ce, dut_start} !== 5'b10000)
            $display("FAIL reset_ctrl: got %b expected 10000", {ap_idle, ap_done, ap_ready, vec_ce, dut_start});
        else passes++;
        checks++;
        if (ap_return !== 32'd0 || dut_a !== '0 || dut_b !== '0)
            $display("FAIL reset_data: got %0d/%h/%h expected 0/0/0", ap_return, dut_a, dut_b);
        else passes++;
        ap_rst_n = 1'b1;
        @(negedge ap_clk);
    endtask

    task automatic test_correct_key();
        int lat; bit done;
        clear_errs(); working_key = LOCK_KEY;
        expect_ret(0); push_ops();
        run(2000, 1'b1, lat, done);
        checks++;
        if (!done || lat !== NOM_LAT) $display("FAIL latency_correct: got %0d (done=%b) expected %0d", lat, done, NOM_LAT);
        else passes++;
        checks++;
        if (hs_cnt !== NUM_VEC) $display("FAIL handshakes_correct: got %0d expected %0d", hs_cnt, NUM_VEC);
        else passes++;
        checks++;
        if (first_pulse !== 1) $display("FAIL start_pulse_len: got %0d expected 1", first_pulse);
        else passes++;
`ifdef LVC_FIRST_FAIL_EN
        checks++;
        if (ff_vld !== 1'b0) $display("FAIL first_fail_vld_clean: got %b expected 0", ff_vld);
        else passes++;
`endif
    endtask

    task automatic test_mismatch();
        int lat; bit done;
        clear_errs(); err_vec[2] = 1'b1; err_vec[7] = 1'b1; err_vec[19] = 1'b1;
        expect_ret(3); push_ops();
        run(2000, 1'b1, lat, done);
        checks++;
        if (!done) $display("FAIL done_mismatch: got 0 expected 1");
        else passes++;
        repeat (3) @(negedge ap_clk);
        checks++;
        if (ap_return !== 32'd3 || ap_idle !== 1'b1 || ap_done !== 1'b0)
            $display("FAIL return_hold: got %0d idle=%b done=%b expected 3 idle=1 done=0", ap_return, ap_idle, ap_done);
        else passes++;
`ifdef LVC_FIRST_FAIL_EN
        checks++;
        if (ff_vld !== 1'b1 || ff_idx !== 5'd2) $display("FAIL first_fail: got %b/%0d expected 1/2", ff_vld, ff_idx);
        else passes++;
`endif
    endtask

    task automatic test_saturate();
        int lat; bit done;
        clear_errs();
        err_vec[0] = 1'b1; err_vec[2] = 1'b1; err_vec[7] = 1'b1; err_vec[10] = 1'b1; err_vec[19] = 1'b1;
        expect_ret(5); push_ops();
        run(2000, 1'b1, lat, done);
        checks++;
        if (!done) $display("FAIL done_saturate: got 0 expected 1");
        else passes++;
    endtask

    task automatic test_key_l0();
        int lat; bit done;
        clear_errs(); working_key = LOCK_KEY ^ 32'h1;
        expect_ret(5);
        run(2000, 1'b0, lat, done);
        checks++;
        if (!done || lat !== NOM_LAT - 5) $display("FAIL latency_l0: got %0d (done=%b) expected %0d", lat, done, NOM_LAT - 5);
        else passes++;
        checks++;
        if (hs_cnt !== NUM_VEC) $display("FAIL handshakes_l0: got %0d expected %0d", hs_cnt, NUM_VEC);
        else passes++;
        working_key = LOCK_KEY;
    endtask

    task automatic test_key_l2();
        int lat; bit done;
        clear_errs(); working_key = LOCK_KEY ^ 32'h4;
        expect_ret(4);
        run(2000, 1'b0, lat, done);
        checks++;
        if (!done || lat !== NOM_LAT) $display("FAIL latency_l2: got %0d (done=%b) expected %0d", lat, done, NOM_LAT);
        else passes++;
        working_key = LOCK_KEY;
    endtask

    task automatic test_key_l1_hang();
        int lat; bit done;
        clear_errs(); working_key = LOCK_KEY ^ 32'h2;
        run(1000, 1'b0, lat, done);
        checks++;
        if (done !== 1'b0) $display("FAIL l1_hang: got done after %0d cycles expected no done within 1000", lat);
        else passes++;
        checks++;
        if (vec_addr !== 5'd4 || hs_cnt <= 5) $display("FAIL l1_stuck_idx: got addr %0d hs %0d expected addr 4 hs>5", vec_addr, hs_cnt);
        else passes++;
        working_key = LOCK_KEY;
        do_reset();
    endtask

    task automatic test_ready_stall();
        int lat; bit done;
        clear_errs(); stall = 4;
        expect_ret(0); push_ops();
        run(2000, 1'b1, lat, done);
        checks++;
        if (first_pulse !== 5) $display("FAIL stall_pulse_len: got %0d expected 5", first_pulse);
        else passes++;
        checks++;
        if (!done || lat !== NOM_LAT + 4) $display("FAIL latency_stall: got %0d (done=%b) expected %0d", lat, done, NOM_LAT + 4);
        else passes++;
        stall = 0;
    endtask

    task automatic test_reset_mid_run();
        int n, bound, lat; bit done;
        clear_errs(); err_vec[3] = 1'b1;
        n = 0; bound = 0;
        @(negedge ap_clk); ap_start = 1'b1;
        @(negedge ap_clk); ap_start = 1'b0;
        while (n < 10 && bound < 500) begin
            @(negedge ap_clk);
            bound++;
            if (dut_start && dut_ready) n++;
        end
        @(negedge ap_clk);
        checks++;
        if (n !== 10 || ap_return !== 32'd1) $display("FAIL pre_reset: got hs %0d ret %0d expected hs 10 ret 1", n, ap_return);
        else passes++;
        ap_rst_n = 1'b0;
        #1;
        checks++;
        if (ap_idle !== 1'b1 || ap_return !== 32'd0 || dut_start !== 1'b0 || vec_ce !== 1'b0)
            $display("FAIL mid_reset: got idle=%b ret=%0d start=%b ce=%b expected 1/0/0/0", ap_idle, ap_return, dut_start, vec_ce);
        else passes++;
        repeat (3) @(negedge ap_clk);
        ap_rst_n = 1'b1;
        @(negedge ap_clk);
        expect_ret(1); push_ops();
        run(2000, 1'b1, lat, done);
        checks++;
        if (first_addr !== 0) $display("FAIL restart_addr: got %0d expected 0", first_addr);
        else passes++;
        checks++;
        if (!done || lat !== NOM_LAT) $display("FAIL latency_restart: got %0d (done=%b) expected %0d", lat, done, NOM_LAT);
        else passes++;
    endtask

    initial begin
        ap_rst_n = 1'b0; ap_start = 1'b0; working_key = LOCK_KEY; dut_ready = 1'b1;
        for (int i = 0; i < 32; i++) begin
            a_rom[i] = {32'hA000_0000 + 32'(i), 32'h1357_9BDF ^ (32'(i) * 32'h0101_0101)};
            b_rom[i] = {32'h5000_0000 + 32'(i * 7), 32'(i) << 4};
            e_rom[i] = {32'hE000_0000 | 32'(i), a_rom[i][31:0] ^ b_rom[i][31:0]};
        end
        clear_errs();
        test_reset();
        test_correct_key();
        test_mismatch();
        test_saturate();
        test_key_l0();
        test_key_l2();
        test_key_l1_hang();
        test_ready_stall();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
